// File: rtl/out_buffer_pkg.sv
// Shared definitions for the multi-channel output capture buffer:
// host register-select encoding, status bit positions and global register indices.
package out_buffer_pkg;

    typedef enum logic [1:0] {
        SEL_DATA   = 2'd0,
        SEL_STAT   = 2'd1,
        SEL_DROP   = 2'd2,
        SEL_GLOBAL = 2'd3
    } sel_e;

    localparam int STAT_OVF_BIT   = 29;
    localparam int STAT_FULL_BIT  = 30;
    localparam int STAT_EMPTY_BIT = 31;

    localparam int GLOBAL_TIME = 0;
    localparam int GLOBAL_ID   = 1;

    localparam int                DROP_W   = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Identification word: {NUM_CH, CNT_W, DATA_W, 8'h00}.
    function automatic logic [31:0] global_id(input int num_ch, input int cnt_w, input int data_w);
        return {8'(num_ch), 8'(cnt_w), 8'(data_w), 8'h00};
    endfunction

endpackage

// File: rtl/out_buffer_ch.sv
// One capture channel: simple dual-port RAM FIFO with count, sticky overflow flag and,
// when OUT_BUFFER_DROP_CNT_EN is defined, a 16-bit saturating drop counter.
module out_buffer_ch
    import out_buffer_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4096,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              pop_req,
    input  logic              stat_rd,
    input  logic              drop_rd,
    output logic              pop_ok,
    output logic [DATA_W-1:0] q,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              drop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop_req && !empty && !clear;
    // A pop in the same cycle frees a slot, so a push on a full channel is still accepted.
    assign push_ok = wr_en && !clear && (!full || pop_ok);
    assign drop    = wr_en && !clear && full && !pop_ok;

    // NOTE: the RAM array is deliberately left without reset so it maps onto block RAM;
    // the non-blocking read returns the old word when full and both ports hit one address.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
        q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (drop) begin
                ovf <= 1'b1;
            end else if (stat_rd) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef OUT_BUFFER_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (clear) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (drop_rd) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (drop_rd) begin
            drop_cnt <= '0;
        end
    end
`else
    logic unused_drop_rd;
    assign unused_drop_rd = drop_rd;
    assign drop_cnt       = '0;
`endif

endmodule

// File: rtl/out_buffer_mc.sv
// Multi-channel output capture buffer: NUM_CH channel FIFOs drained by a host slave with
// fixed 2-cycle read latency. Drop counters are built only with OUT_BUFFER_DROP_CNT_EN.
module out_buffer_mc
    import out_buffer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4096,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int ADDR_W = 2 + CH_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]        clear,
    input  logic [31:0]              total_time,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        address,
    output logic [31:0]              readdata,
    output logic                     readdatavalid,
    output logic [NUM_CH-1:0]        ovf
);

    logic             access;
    sel_e             acc_sel;
    logic [CH_W-1:0]  acc_ch;
    logic [NUM_CH-1:0] ch_hit;
    logic [31:0]      acc_word;

    logic [NUM_CH-1:0]             pop_ok;
    logic [NUM_CH-1:0][DATA_W-1:0] q;
    logic [NUM_CH-1:0][CNT_W-1:0]  count;
    logic [NUM_CH-1:0]             full;
    logic [NUM_CH-1:0]             empty;
    logic [NUM_CH-1:0][DROP_W-1:0] drop_cnt;

    logic             s1_valid;
    logic             s1_pop_hit;
    logic [CH_W-1:0]  s1_ch;
    logic [31:0]      s1_word;
    logic [31:0]      q_word;

    assign access  = chipselect && read;
    assign acc_sel = sel_e'(address[ADDR_W-1 -: 2]);
    assign acc_ch  = address[CH_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_hit[c] = (acc_ch == CH_W'(c));

        out_buffer_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (wr_en[c]),
            .wr_data  (wr_data[c*DATA_W +: DATA_W]),
            .clear    (clear[c]),
            .pop_req  (access && (acc_sel == SEL_DATA) && ch_hit[c]),
            .stat_rd  (access && (acc_sel == SEL_STAT) && ch_hit[c]),
            .drop_rd  (access && (acc_sel == SEL_DROP) && ch_hit[c]),
            .pop_ok   (pop_ok[c]),
            .q        (q[c]),
            .count    (count[c]),
            .full     (full[c]),
            .empty    (empty[c]),
            .ovf      (ovf[c]),
            .drop_cnt (drop_cnt[c])
        );
    end

    // Register word captured at access time, so read-to-clear returns the pre-clear state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_word = '0;
        if (acc_sel == SEL_GLOBAL) begin
            if (acc_ch == CH_W'(GLOBAL_TIME)) begin
                acc_word = total_time;
            end else if (acc_ch == CH_W'(GLOBAL_ID)) begin
                acc_word = global_id(NUM_CH, CNT_W, DATA_W);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_hit[c]) begin
                if (acc_sel == SEL_STAT) begin
                    acc_word[CNT_W-1:0]     = count[c];
                    acc_word[STAT_OVF_BIT]   = ovf[c];
                    acc_word[STAT_FULL_BIT]  = full[c];
                    acc_word[STAT_EMPTY_BIT] = empty[c];
                end else if (acc_sel == SEL_DROP) begin
                    acc_word[DROP_W-1:0] = drop_cnt[c];
                end
            end
        end
    end

    always_comb begin
        q_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s1_ch == CH_W'(c)) begin
                q_word[DATA_W-1:0] = q[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid      <= 1'b0;
            s1_pop_hit    <= 1'b0;
            s1_ch         <= '0;
            s1_word       <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            s1_valid      <= access;
            s1_pop_hit    <= |pop_ok;
            s1_ch         <= acc_ch;
            s1_word       <= acc_word;
            readdatavalid <= s1_valid;
            if (s1_valid) begin
                readdata <= s1_pop_hit ? q_word : s1_word;
            end
        end
    end

endmodule
